// File: rtl/wieg_sturing.sv
// -----------------------------------------------------------------------------
// wieg_sturing -- cradle rocking controller
//
// Purpose:
//   Rocks a cradle in sessions. While rocking (WIEG) the controller counts
//   clk12 strobes. Every EVAL_TICKS strobes it spends one cycle (EVAL)
//   judging the baby's stress indicators and adapts the rocking speed and
//   pattern. The session ends calm (KLAAR) after CALM_TARGET consecutive
//   "stress decreased" evaluations. It gives up (ALARM) after MAX_POGINGEN
//   evaluations without calming.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   clk12     in   single-cycle evaluation strobe, synchronous to clk
//   start     in   level, starts a session from IDLE
//   stop      in   level, aborts any session and overrides everything else
//   gedaald   in   stress decreased, sampled in EVAL
//   gelijk    in   stress unchanged, sampled in EVAL
//   motor_en  out  cradle motor enable
//   stand     out  rocking pattern 0..3
//   snelheid  out  applied rocking speed 0..7
//   bezig     out  session active
//   klaar     out  session ended calm
//   alarm     out  session gave up
//
// Configuration:
//   WIEG_ZACHTE_START_EN  when defined, the applied speed ramps one step per
//                         clk12 strobe toward the target speed. When left
//                         undefined, the applied speed follows the target
//                         speed directly.
// -----------------------------------------------------------------------------
module wieg_sturing #(
   parameter int EVAL_TICKS   = 8,
   parameter int CALM_TARGET  = 3,
   parameter int MAX_POGINGEN = 12
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clk12,
   input  logic       start,
   input  logic       stop,
   input  logic       gedaald,
   input  logic       gelijk,
   output logic       motor_en,
   output logic [1:0] stand,
   output logic [2:0] snelheid,
   output logic       bezig,
   output logic       klaar,
   output logic       alarm
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_WIEG  = 3'd1;
   localparam logic [2:0] ST_EVAL  = 3'd2;
   localparam logic [2:0] ST_KLAAR = 3'd3;
   localparam logic [2:0] ST_ALARM = 3'd4;

   localparam logic [7:0] TICK_LAST = 8'(EVAL_TICKS - 1);
   localparam logic [3:0] CALM_LAST = 4'(CALM_TARGET);
   localparam logic [7:0] TRY_LAST  = 8'(MAX_POGINGEN);

   localparam logic [2:0] SPEED_MIN     = 3'd1;
   localparam logic [2:0] SPEED_MAX     = 3'd7;
   localparam logic [2:0] SPEED_RESTART = 3'd3;

   logic [2:0] state;
   logic [2:0] state_nxt;
   logic [7:0] tick_cnt;
   logic [7:0] tick_nxt;
   logic [3:0] calm_cnt;
   logic [3:0] calm_nxt;
   logic [7:0] try_cnt;
   logic [7:0] try_nxt;
   logic [2:0] target;
   logic [2:0] target_nxt;
   logic [1:0] pattern;
   logic [1:0] pattern_nxt;
   logic [2:0] speed;
   logic [2:0] speed_nxt;
   logic       running_nxt;

   // Next-state and session bookkeeping. The per-state rules are applied
   // first; stop and the IDLE cleanup are layered on top afterwards so that
   // an abort always discards whatever the state rules decided in that cycle,
   // including an evaluation that would otherwise have been applied.
   always_comb begin
      state_nxt   = state;
      tick_nxt    = tick_cnt;
      calm_nxt    = calm_cnt;
      try_nxt     = try_cnt;
      target_nxt  = target;
      pattern_nxt = pattern;
      speed_nxt   = speed;

      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_WIEG;
            end
         end

         ST_WIEG: begin
            if (clk12) begin
               if (tick_cnt == TICK_LAST) begin
                  tick_nxt  = 8'd0;
                  state_nxt = ST_EVAL;
               end else begin
                  tick_nxt = tick_cnt + 8'd1;
               end
`ifdef WIEG_ZACHTE_START_EN
               if (speed < target) begin
                  speed_nxt = speed + 3'd1;
               end else if (speed > target) begin
                  speed_nxt = speed - 3'd1;
               end
`endif
            end
         end

         ST_EVAL: begin
            try_nxt   = try_cnt + 8'd1;
            state_nxt = ST_WIEG;
            if (gedaald) begin
               if (target > SPEED_MIN) begin
                  target_nxt = target - 3'd1;
               end
               calm_nxt = calm_cnt + 4'd1;
               if (calm_nxt == CALM_LAST) begin
                  state_nxt = ST_KLAAR;
               end
            end else if (gelijk) begin
               pattern_nxt = pattern + 2'd1;
               calm_nxt    = 4'd0;
            end else begin
               calm_nxt = 4'd0;
               if (target != SPEED_MAX) begin
                  target_nxt = target + 3'd1;
               end else begin
                  pattern_nxt = pattern + 2'd1;
                  target_nxt  = SPEED_RESTART;
               end
            end
            if ((state_nxt != ST_KLAAR) && (try_nxt == TRY_LAST)) begin
               state_nxt = ST_ALARM;
            end
         end

         ST_KLAAR: begin
            if (!start) begin
               state_nxt = ST_IDLE;
            end
         end

         ST_ALARM: begin
            state_nxt = ST_ALARM;
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      if (stop) begin
         state_nxt = ST_IDLE;
      end

      // Everything is put back to its session-entry value while idle, so a
      // new session always starts from pattern 0 at speed 1 with clean
      // counters.
      if (state_nxt == ST_IDLE) begin
         tick_nxt    = 8'd0;
         calm_nxt    = 4'd0;
         try_nxt     = 8'd0;
         target_nxt  = SPEED_MIN;
         pattern_nxt = 2'd0;
         speed_nxt   = SPEED_MIN;
      end

`ifndef WIEG_ZACHTE_START_EN
      // Without the soft start the applied speed is simply the target speed.
      speed_nxt = target_nxt;
`endif
   end

   assign running_nxt = (state_nxt == ST_WIEG) || (state_nxt == ST_EVAL);

   // Internal state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         tick_cnt <= 8'd0;
         calm_cnt <= 4'd0;
         try_cnt  <= 8'd0;
         target   <= SPEED_MIN;
         pattern  <= 2'd0;
         speed    <= SPEED_MIN;
      end else begin
         state    <= state_nxt;
         tick_cnt <= tick_nxt;
         calm_cnt <= calm_nxt;
         try_cnt  <= try_nxt;
         target   <= target_nxt;
         pattern  <= pattern_nxt;
         speed    <= speed_nxt;
      end
   end

   // Output registers, decoded from the next state so they line up with the
   // state register rather than lagging it by a cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         motor_en <= 1'b0;
         stand    <= 2'd0;
         snelheid <= 3'd0;
         bezig    <= 1'b0;
         klaar    <= 1'b0;
         alarm    <= 1'b0;
      end else begin
         motor_en <= running_nxt;
         bezig    <= running_nxt;
         stand    <= pattern_nxt;
         snelheid <= running_nxt ? speed_nxt : 3'd0;
         klaar    <= (state_nxt == ST_KLAAR);
         alarm    <= (state_nxt == ST_ALARM);
      end
   end

endmodule
